// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator with read-modify-write sub-word stores
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid, opcode, addr, store_data, pc  : memory instruction from the MEM stage
//   stall, done, load_data, align_err        : pipeline-side status and load result
//   mem_req, mem_we, mem_addr, mem_wdata     : word-wide request to data memory
//   mem_ready, mem_rvalid, mem_rdata         : data-memory handshake and read return
module mem_access_unit #(
    parameter int ADDR_W = 11,
    parameter bit TRACE  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [5:0]        opcode,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    input  logic [31:0]       pc,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              align_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    state_t      state;
    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [15:0] data_q;   // only the low half of store data is needed after IDLE (sb/sh merge)
    logic [31:0] pc_q;

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:          return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH:  return lo[0];
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic needs_read(input logic [5:0] op);
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] lane,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Overlay the store byte/half onto the word just read; memory has no byte enables.
    function automatic logic [31:0] merge(input logic [5:0] op, input logic [1:0] lane,
                                          input logic [31:0] w, input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (op == OP_SB)
            r[{lane, 3'b000} +: 8] = d[7:0];
        else if (lane[1])
            r[31:16] = d;
        else
            r[15:0] = d;
        return r;
    endfunction

    assign stall = (state == IDLE && req_valid) || (state != IDLE && state != DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            pc_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_data <= '0;
            done      <= 1'b0;
            align_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            align_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= opcode;
                        addr_q   <= addr;
                        data_q   <= store_data[15:0];
                        pc_q     <= pc;
                        mem_addr <= addr[ADDR_W+1:2];
                        if (is_misaligned(opcode, addr[1:0])) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            align_err <= 1'b1;
                        end else if (opcode == OP_SW) begin
                            state     <= WR_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= store_data;
                        end else if (needs_read(opcode)) begin
                            state   <= RD_REQ;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        if (op_q == OP_SB || op_q == OP_SH) begin
                            mem_wdata <= merge(op_q, addr_q[1:0], mem_rdata, data_q);
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            load_data <= extract(op_q, addr_q[1:0], mem_rdata);
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WR_REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    if (TRACE) begin : g_trace
        always_ff @(posedge clk) begin
            if (reset && state == WR_REQ && mem_ready)
                $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, mem_wdata);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        align_err;
    logic        mem_req;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        rvalid_en;
    int          wr_count = 0;
    int          req_cycles = 0;
    int          vec = 0;
    int          errs = 0;
    logic [31:0] mem [0:2047] = '{16: 32'h8899AABB, default: 32'h0};

    mem_access_unit #(.ADDR_W(11), .TRACE(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .opcode     (opcode),
        .addr       (addr),
        .store_data (store_data),
        .pc         (pc),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .align_err  (align_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory responder: read data returns the cycle after acceptance.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= 32'h0;
        end else begin
            mem_rvalid <= 1'b0;
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    mem[mem_addr] <= mem_wdata;
                    wr_count      <= wr_count + 1;
                end else if (rvalid_en) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= mem[mem_addr];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_req) req_cycles <= req_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge (cycle 0); returns the cycle in which done was seen.
    task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic ae);
        req_valid  = 1'b1;
        opcode     = op;
        addr       = a;
        store_data = d;
        pc         = 32'h0040_0100 + a;
        lat        = -1;
        ae         = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                ae  = align_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int   lat;
        logic ae;
        int   w0;
        int   r0;

        reset = 1'b0; req_valid = 1'b0; opcode = '0; addr = '0; store_data = '0; pc = '0;
        mem_ready = 1'b1; rvalid_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_align", align_err, 0);
        check("rst_stall", stall, 0);
        check("rst_load_data", load_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run(OP_LB, 32'h42, 0, lat, ae);
        check("lb_lat", lat, 3);
        check("lb_data", load_data, 32'hFFFFFF99);
        check("lb_align", ae, 0);
        run(OP_LBU, 32'h42, 0, lat, ae);
        check("lbu_lat", lat, 3);
        check("lbu_data", load_data, 32'h00000099);
        run(OP_LH, 32'h40, 0, lat, ae);
        check("lh_data", load_data, 32'hFFFFAABB);
        run(OP_LHU, 32'h42, 0, lat, ae);
        check("lhu_data", load_data, 32'h00008899);
        run(OP_LW, 32'h40, 0, lat, ae);
        check("lw_lat", lat, 3);
        check("lw_data", load_data, 32'h8899AABB);

        w0 = wr_count;
        run(OP_SB, 32'h41, 32'h12345677, lat, ae);
        check("sb_lat", lat, 4);
        check("sb_word", mem[16], 32'h889977BB);
        check("sb_writes", wr_count, w0 + 1);
        check("sb_load_kept", load_data, 32'h8899AABB);

        r0 = req_cycles;
        run(OP_SH, 32'h43, 32'hFFFF, lat, ae);
        check("sh_mis_lat", lat, 1);
        check("sh_mis_align", ae, 1);
        run(OP_LW, 32'h06, 0, lat, ae);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_align", ae, 1);
        check("mis_no_req", req_cycles, r0);
        check("mis_load_kept", load_data, 32'h8899AABB);

        run(6'b000000, 32'h40, 0, lat, ae);
        check("unsup_lat", lat, 1);
        check("unsup_align", ae, 0);
        check("unsup_load_kept", load_data, 32'h8899AABB);

        run(OP_SH, 32'h42, 32'h5555CAFE, lat, ae);
        check("sh_lat", lat, 4);
        check("sh_word", mem[16], 32'hCAFE77BB);
        run(OP_LH, 32'h42, 0, lat, ae);
        check("lh_hi_data", load_data, 32'hFFFFCAFE);

        run(OP_SW, 32'h84, 32'h01234567, lat, ae);
        check("sw_lat", lat, 2);
        check("sw_word", mem[33], 32'h01234567);

        // Back-pressure on a store; inputs change mid-access and must be ignored.
        mem_ready = 1'b0;
        req_valid = 1'b1; opcode = OP_SW; addr = 32'h80; store_data = 32'hDEADBEEF;
        @(negedge clk);
        check("bp_stall_c0", stall, 1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_req", mem_req, 1);
            check("bp_we", mem_we, 1);
            check("bp_addr", mem_addr, 32'h20);
            check("bp_wdata", mem_wdata, 32'hDEADBEEF);
            check("bp_stall", stall, 1);
            addr = 32'h44; store_data = 32'h0;
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_done", done, 1);
        check("bp_done_stall", stall, 0);
        check("bp_done_req", mem_req, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_word", mem[32], 32'hDEADBEEF);

        // Reset during RD_WAIT of an sb: the write is abandoned.
        w0 = wr_count;
        rvalid_en = 1'b0;
        req_valid = 1'b1; opcode = OP_SB; addr = 32'h40; store_data = 32'hAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rw_stall", stall, 1);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rw_rst_stall", stall, 0);
        check("rw_rst_req", mem_req, 0);
        check("rw_rst_load", load_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rvalid_en = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rw_no_write", wr_count, w0);
        check("rw_word_kept", mem[16], 32'hCAFE77BB);
        run(OP_LW, 32'h40, 0, lat, ae);
        check("post_rst_lat", lat, 3);
        check("post_rst_data", load_data, 32'hCAFE77BB);

        // Reset while RD_REQ is outstanding: mem_req drops without a clock edge.
        mem_ready = 1'b0;
        req_valid = 1'b1; opcode = OP_SB; addr = 32'h40; store_data = 32'h11;
        @(posedge clk); #1;
        @(negedge clk);
        check("rq_req", mem_req, 1);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rq_async_drop", mem_req, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rq_no_write", wr_count, w0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store initiator for the 5-stage MIPS pipeline. It takes one memory instruction at a time (opcode, byte address, store data) and turns it into word-wide transactions on a valid/ready data-memory port. Sub-word loads are extracted and extended. Sub-word stores are done as read-modify-write, because the memory port has no byte enables. The pipeline is stalled until the access completes.

Parameters:
ADDR_W, 11, word-index width on the memory port (2048 words); word index = addr[ADDR_W+1:2], upper bits ignored
TRACE, 1, when 1, print a simulation trace line on every accepted memory write

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low; forces FSM and all registered outputs to reset values
req_valid  in  1  MEM stage holds a memory instruction; held stable while stall=1
opcode  in  6  lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001
addr  in  32  byte address
store_data  in  32  rt value for stores
pc  in  32  instruction PC, used for trace only
stall  out  1  combinational: (state==IDLE && req_valid) || (state!=IDLE && state!=DONE)
done  out  1  one-cycle pulse when the access completes
load_data  out  32  extended load result, registered, held until the next load completes
align_err  out  1  one-cycle pulse alongside done for a misaligned access
mem_req  out  1  memory request valid (Moore, from state)
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word index
mem_wdata  out  32  full word to write
mem_ready  in  1  memory accepts the request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE; mem_req, mem_we, done, align_err = 0; mem_addr, mem_wdata, load_data = 0; internal captured address, opcode, data and merged word all 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE, req_valid=1: capture opcode, addr, store_data, pc; then branch:
  - misaligned -> DONE with align_err. Misaligned means lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]!=0. No memory traffic.
  - sw -> WR_REQ with mem_wdata=store_data.
  - all loads, sb, sh -> RD_REQ.
  - unsupported opcode -> DONE, no traffic, load_data unchanged.
- RD_REQ: mem_req=1, mem_we=0. Stay until mem_ready=1, then RD_WAIT.
- RD_WAIT: wait for mem_rvalid. mem_rvalid is legal no earlier than the cycle after acceptance. On mem_rvalid:
  - loads: compute load_data, go to DONE.
  - sb: replace byte lane addr[1:0] of mem_rdata with store_data[7:0] (lane 0 = bits 7:0 ... lane 3 = bits 31:24), go to WR_REQ.
  - sh: replace half addr[1] of mem_rdata (0 = bits 15:0, 1 = bits 31:16) with store_data[15:0], go to WR_REQ.
- Load extraction:
  - lb: sign-extend selected byte. lbu: zero-extend selected byte.
  - lh: sign-extend selected half. lhu: zero-extend selected half.
  - lw: whole word.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata=final word. On mem_ready go to DONE. When TRACE=1, print "@<pc>: *<{addr[31:2],2'b00}> <= <word>" in hex.
- DONE: done=1 for exactly one cycle, stall=0, mem_req=0; next state IDLE unconditionally. The pipeline advances on this edge. A new request is sampled in IDLE the following cycle.
- Minimum latency, done cycle counted from request cycle 0, with ready=1 and rvalid in the following cycle:
  - loads: done in cycle 3.
  - sw: done in cycle 2.
  - sb/sh: done in cycle 4.
  - misaligned/unsupported: done in cycle 1.
- Back-pressure: mem_req, mem_we, mem_addr and mem_wdata are held stable while mem_ready=0. There is no timeout.
- mem_rvalid outside RD_WAIT is ignored. mem_ready outside RD_REQ/WR_REQ is ignored.
- Captured request fields are not re-sampled after IDLE; input changes mid-access have no effect.
- Reset mid-access: immediate return to IDLE; mem_req drops asynchronously. A pending RMW write is abandoned and memory is not written.

Test Plan:
- Word 0x10 holds 0x8899AABB; lb addr 0x42 -> load_data 0xFFFFFF99. lbu addr 0x42 -> 0x00000099. Each done in cycle 3 with mem_ready=1 and rvalid one cycle later.
- Same word, lh addr 0x40 -> 0xFFFFAABB; lhu addr 0x42 -> 0x00008899; lw addr 0x40 -> 0x8899AABB.
- sb addr 0x41, store_data 0x12345677 over 0x8899AABB -> one read then one write of 0x889977BB to mem_addr 0x10; done cycle 4; trace "@pc: *00000040 <= 889977bb".
- sh addr 0x43 and lw addr 0x06 -> align_err and done pulse together in cycle 1, mem_req never asserted, load_data unchanged.
- sw addr 0x80, 0xDEADBEEF with mem_ready low for 3 cycles -> mem_req/mem_addr 0x20/mem_wdata held stable, stall high throughout, done the cycle after acceptance.
- sb in RD_WAIT, reset pulsed low -> mem_req=0 immediately, no write issued; after release, a new lw completes normally.
